float_to_fixed: RTL

- Iterative converter from 32-bit IEEE-754 single precision to signed two's-complement fixed point. Output has OUT_WIDTH total bits, of which FRAC_BITS are fractional.
- Sits downstream of the floating-point ALU. Returns ALU results to the fixed-point filter datapath; it is the unpacking counterpart of the ALU's IEEE-754 packing.
- Valid/ready handshake on both sides. One conversion in flight at a time. Mantissa alignment is done by a one-bit-per-cycle shifter, not a barrel shifter.

---
 rtl/float_to_fixed.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/float_to_fixed.sv
// Iterative IEEE-754 single-precision to signed fixed-point converter (one-bit-per-cycle aligner).
// Optional round-to-nearest-even in the final stage when ROUND_NEAREST_EN is defined; truncation otherwise.
`timescale 1ns/1ps
module float_to_fixed #(
  parameter int OUT_WIDTH = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 a_operand,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] result,
  output logic                        overflow,
  output logic                        invalid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_FIN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                  state;
  logic [OUT_WIDTH-1:0]        mag;
  logic                        guard;
  logic                        sticky;
  logic [4:0]                  cnt;
  logic                        shift_left;
  logic                        neg;

  logic                        sign_f;
  logic [7:0]                  exp_f;
  logic [22:0]                 frac_f;
  logic signed [10:0]          p_pos;
  logic signed [10:0]          diff;
  logic [4:0]                  n_amt;
  logic                        is_special;
  logic signed [OUT_WIDTH-1:0] spec_res;
  logic                        spec_ovf;
  logic                        spec_inv;
  logic signed [OUT_WIDTH-1:0] fin_res;
  logic                        fin_ovf;

  function automatic logic signed [OUT_WIDTH-1:0] sat_value(input logic negative);
    return negative ? $signed({1'b1, {(OUT_WIDTH-1){1'b0}}})
                    : $signed({1'b0, {(OUT_WIDTH-1){1'b1}}});
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] apply_sign(input logic negative,
                                                             input logic [OUT_WIDTH-1:0] m);
    return negative ? -$signed(m) : $signed(m);
  endfunction

`ifdef ROUND_NEAREST_EN
  function automatic logic [OUT_WIDTH-1:0] round_nearest(input logic [OUT_WIDTH-1:0] m,
                                                          input logic g,
                                                          input logic s);
    return m + {{(OUT_WIDTH-1){1'b0}}, g & (s | m[0])};
  endfunction
`endif

  // Accept stage: decode the operand into shift direction/amount or a special result
  assign sign_f = a_operand[31];
  assign exp_f  = a_operand[30:23];
  assign frac_f = a_operand[22:0];
  assign p_pos  = $signed({3'b000, exp_f}) - 11'sd127 + 11'(FRAC_BITS);
  assign diff   = p_pos - 11'sd23;
  assign n_amt  = diff[10] ? 5'(-diff) : 5'(diff);

  always_comb begin
    is_special = 1'b1;
    spec_res   = '0;
    spec_ovf   = 1'b0;
    spec_inv   = 1'b0;
    if (exp_f == 8'hFF) begin
      if (frac_f != 23'd0) begin
        spec_inv = 1'b1;
      end else begin
        spec_res = sat_value(sign_f);
        spec_ovf = 1'b1;
      end
    end else if (exp_f == 8'd0) begin
      spec_res = '0;
    end else if (p_pos >= 11'(OUT_WIDTH-1)) begin
      // -2^(OUT_WIDTH-1) is representable exactly, so it is not an overflow
      spec_res = sat_value(sign_f);
      spec_ovf = !(sign_f && (p_pos == 11'(OUT_WIDTH-1)) && (frac_f == 23'd0));
    end else if (p_pos < -11'sd2) begin
      spec_res = '0;
    end else begin
      is_special = 1'b0;
    end
  end

  // Final stage: optional rounding, then sign application
`ifdef ROUND_NEAREST_EN
  logic [OUT_WIDTH-1:0] rounded;
  always_comb begin
    rounded = round_nearest(mag, guard, sticky);
    fin_ovf = rounded[OUT_WIDTH-1] && !neg;
    fin_res = fin_ovf ? sat_value(1'b0) : apply_sign(neg, rounded);
  end
`else
  always_comb begin
    fin_ovf = 1'b0;
    fin_res = apply_sign(neg, mag);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      result   <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
      cnt      <= '0;
      guard    <= 1'b0;
      sticky   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            neg        <= sign_f;
            mag        <= {{(OUT_WIDTH-24){1'b0}}, 1'b1, frac_f};
            guard      <= 1'b0;
            sticky     <= 1'b0;
            cnt        <= n_amt;
            shift_left <= (diff > 11'sd0);
            if (is_special) begin
              result   <= spec_res;
              overflow <= spec_ovf;
              invalid  <= spec_inv;
              state    <= S_DONE;
            end else begin
              state    <= S_SHIFT;
            end
          end
        end
        // Alignment stage: one bit per cycle, guard/sticky collect the bits shifted out
        S_SHIFT: begin
          if (cnt == 5'd0) begin
            state <= S_FIN;
          end else begin
            if (shift_left) begin
              mag <= {mag[OUT_WIDTH-2:0], 1'b0};
            end else begin
              mag    <= {1'b0, mag[OUT_WIDTH-1:1]};
              guard  <= mag[0];
              sticky <= sticky | guard;
            end
            cnt <= cnt - 5'd1;
          end
        end
        S_FIN: begin
          result   <= fin_res;
          overflow <= fin_ovf;
          invalid  <= 1'b0;
          state    <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule
